// File: rtl/led_seq_decoder.sv
// led_seq_decoder: decodes a select or an internal sequencer index onto active-low LEDs.
// Latency: led is registered, one clock after inputs/state; backpressure: none (free-running display).
// Optional blink gating is compiled in with the LED_BLINK_EN macro (adds the blink input).
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   enable  - block is active when enable == EN_CODE, otherwise all LEDs off
//   switch  - select index for DECODE (00) and THERMO (11)
//   mode    - 00 DECODE, 01 SCAN, 10 BOUNCE, 11 THERMO
//   led     - active-low LED drive, 2**SEL_W bits
//   blink   - (LED_BLINK_EN only) forces LEDs off during the second half of each blink period
module led_seq_decoder #(
  parameter int         SEL_W     = 3,
  parameter logic [2:0] EN_CODE   = 3'd4,
  parameter int         DIV       = 4,
  parameter int         BLINK_DIV = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            enable,
  input  logic [SEL_W-1:0]      switch,
  input  logic [1:0]            mode,
  output logic [2**SEL_W-1:0]   led
`ifdef LED_BLINK_EN
  ,
  input  logic                  blink
`endif
);

  localparam int N_LED = 2**SEL_W;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] MODE_DECODE = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_THERMO = 2'b11;

  localparam logic [N_LED-1:0] ONE  = N_LED'(1);
  localparam logic [N_LED-1:0] ONES = '1;

  // Reject illegal parameterisations at elaboration time.
  if (SEL_W < 1 || SEL_W > 5) begin : g_bad_sel_w
    $error("led_seq_decoder: SEL_W must be 1..5");
  end
  if (DIV < 1) begin : g_bad_div
    $error("led_seq_decoder: DIV must be >= 1");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("led_seq_decoder: BLINK_DIV must be >= 1");
  end

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [PW-1:0]    pre_q, pre_d;
  dir_t             dir_q, dir_d;
  logic [1:0]       mode_q;
  logic [N_LED-1:0] led_q, led_d;

  logic             en;
  logic             entry;
  logic             step;
  logic [N_LED-1:0] therm;

  assign en    = (enable == EN_CODE);
  assign entry = (mode != mode_q);
  assign step  = (pre_q == PW'(DIV - 1));

  // Thermometer of switch+1 ones: shifting all-ones right by (N_LED-1-switch),
  // and N_LED-1-switch is simply ~switch at SEL_W bits. Avoids a carry bit.
  assign therm = ONES >> (~switch);

`ifdef LED_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_DIV);
  logic [BW-1:0] bc_q;

  // Free-running blink phase counter, independent of en and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc_q <= '0;
    end else if (bc_q == BW'(2 * BLINK_DIV - 1)) begin
      bc_q <= '0;
    end else begin
      bc_q <= bc_q + BW'(1);
    end
  end
`endif

  always_comb begin
    idx_d = idx_q;
    pre_d = pre_q;
    dir_d = dir_q;
    led_d = ONES;

    if (en) begin
      if (entry) begin
        // New mode always starts its sequence from LED0, going up.
        idx_d = '0;
        pre_d = '0;
        dir_d = DIR_UP;
      end else if (mode == MODE_SCAN || mode == MODE_BOUNCE) begin
        pre_d = step ? '0 : pre_q + PW'(1);
        if (step) begin
          if (mode == MODE_SCAN) begin
            idx_d = idx_q + SEL_W'(1);  // natural wrap at N_LED
          end else if (dir_q == DIR_UP) begin
            // Turn around at the top end without repeating the end LED.
            if (idx_q == SEL_W'(N_LED - 1)) begin
              dir_d = DIR_DOWN;
              idx_d = SEL_W'(N_LED - 2);
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end else begin
            if (idx_q == '0) begin
              dir_d = DIR_UP;
              idx_d = SEL_W'(1);
            end else begin
              idx_d = idx_q - SEL_W'(1);
            end
          end
        end
      end

      case (mode)
        MODE_DECODE: led_d = ~(ONE << switch);
        MODE_THERMO: led_d = ~therm;
        default:     led_d = ~(ONE << idx_d);  // sequenced modes show the new index
      endcase
    end

`ifdef LED_BLINK_EN
    if (blink && bc_q >= BW'(BLINK_DIV)) begin
      led_d = ONES;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= ONES;
      idx_q  <= '0;
      pre_q  <= '0;
      dir_q  <= DIR_UP;
      mode_q <= MODE_DECODE;
    end else begin
      led_q  <= led_d;
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      dir_q  <= dir_d;
      mode_q <= mode;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_seq_decoder.sv
module tb_led_seq_decoder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] enable;
  logic [2:0] switch;
  logic [1:0] mode;
  logic [7:0] led0;   // DIV = 4 instance
  logic [7:0] led1;   // DIV = 1 instance
`ifdef LED_BLINK_EN
  logic       blink = 1'b0;
`endif

  led_seq_decoder #(.SEL_W(3), .EN_CODE(3'd4), .DIV(4), .BLINK_DIV(8)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .switch(switch), .mode(mode), .led(led0)
`ifdef LED_BLINK_EN
    , .blink(blink)
`endif
  );

  led_seq_decoder #(.SEL_W(3), .EN_CODE(3'd4), .DIV(1), .BLINK_DIV(8)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .switch(switch), .mode(mode), .led(led1)
`ifdef LED_BLINK_EN
    , .blink(blink)
`endif
  );

  typedef struct {
    logic [7:0] exp;
    bit         sel;
    string      name;
  } sb_t;

  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic [2:0] sw;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[13];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic r, input logic [2:0] e, input logic [2:0] s, input logic [1:0] m);
    rst    = r;
    enable = e;
    switch = s;
    mode   = m;
  endtask

  task automatic expect_led(input logic [7:0] e, input bit sel, input string nm);
    sb_t s;
    s.exp  = e;
    s.sel  = sel;
    s.name = nm;
    sbq.push_back(s);
  endtask

  // Advance one edge, then compare every queued expectation against the DUT it names.
  task automatic tick();
    sb_t        s;
    logic [7:0] act;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      s   = sbq.pop_front();
      act = s.sel ? led1 : led0;
      checks++;
      if (act !== s.exp) begin
        errors++;
        $display("FAIL %s: led=%h expected %h at %0t", s.name, act, s.exp, $time);
      end
    end
  endtask

  function automatic logic [7:0] dec(input int i);
    logic [7:0] v;
    v = 8'h01 << i;
    return ~v;
  endfunction

  function automatic int bpos(input int p);
    int q;
    q = p % 14;
    return (q <= 7) ? q : 14 - q;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 3'd4, 3'd5, 2'd0, 8'hFF};  // reset
    vt[1]  = '{1'b1, 3'd4, 3'd5, 2'd0, 8'hFF};
    vt[2]  = '{1'b0, 3'd4, 3'd5, 2'd0, 8'hDF};  // decode 5
    vt[3]  = '{1'b0, 3'd4, 3'd0, 2'd0, 8'hFE};
    vt[4]  = '{1'b0, 3'd3, 3'd2, 2'd0, 8'hFF};  // wrong enable
    vt[5]  = '{1'b0, 3'd4, 3'd2, 2'd0, 8'hFB};
    vt[6]  = '{1'b0, 3'd0, 3'd2, 2'd0, 8'hFF};
    vt[7]  = '{1'b0, 3'd4, 3'd3, 2'd3, 8'hF0};  // thermo
    vt[8]  = '{1'b0, 3'd4, 3'd7, 2'd3, 8'h00};
    vt[9]  = '{1'b0, 3'd4, 3'd0, 2'd3, 8'hFE};
    vt[10] = '{1'b0, 3'd5, 3'd0, 2'd3, 8'hFF};
    vt[11] = '{1'b0, 3'd4, 3'd6, 2'd0, 8'hBF};
    vt[12] = '{1'b1, 3'd4, 3'd6, 2'd0, 8'hFF};  // reset wins

    drive(1'b1, 3'd4, 3'd5, 2'd0);
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].rst, vt[i].en, vt[i].sw, vt[i].mode);
      expect_led(vt[i].exp, 1'b0, $sformatf("vec%0d", i));
      tick();
    end

    // SCAN from DECODE: each index held 4 cycles; pause at index 5 mid-dwell.
    for (int k = 0; k < 22; k++) begin
      drive(1'b0, 3'd4, 3'd0, 2'd1);
      expect_led(dec((k / 4) % 8), 1'b0, $sformatf("scan k%0d", k));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'd1, 3'd0, 2'd1);
      expect_led(8'hFF, 1'b0, "scan disabled");
      tick();
    end
    for (int k = 22; k < 38; k++) begin
      drive(1'b0, 3'd4, 3'd0, 2'd1);
      expect_led(dec((k / 4) % 8), 1'b0, $sformatf("scan resume k%0d", k));
      tick();
    end

    // Back to DECODE, restart SCAN, reset at index 5.
    drive(1'b0, 3'd4, 3'd0, 2'd0);
    expect_led(8'hFE, 1'b0, "decode between scans");
    tick();
    for (int k = 0; k < 22; k++) begin
      drive(1'b0, 3'd4, 3'd0, 2'd1);
      expect_led(dec((k / 4) % 8), 1'b0, $sformatf("rescan k%0d", k));
      tick();
    end
    drive(1'b1, 3'd4, 3'd0, 2'd1);
    expect_led(8'hFF, 1'b0, "mid-scan reset");
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 3'd4, 3'd0, 2'd1);
      expect_led(dec(k / 4), 1'b0, $sformatf("post-reset scan k%0d", k));
      tick();
    end

    // BOUNCE on both instances: DIV=1 steps each cycle, DIV=4 every 4th.
    for (int k = 0; k < 60; k++) begin
      drive(1'b0, 3'd4, 3'd0, 2'd2);
      expect_led(dec(bpos(k)), 1'b1, $sformatf("bounce div1 k%0d", k));
      expect_led(dec(bpos(k / 4)), 1'b0, $sformatf("bounce div4 k%0d", k));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
